// File: rtl/rng_spawn_scheduler.sv
// Round-robin scheduler that shares one 4-bit RNG among NUM_LANES requesters.
// Optional feature macro RNG_REJECT_ZERO_EN: re-sample zero values up to 3 times, then deliver 4'h1.
module rng_spawn_scheduler #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned SETTLE    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_LANES-1:0] req,
    input  logic [3:0]           rng_value,
    output logic [2:0]           rng_mode,
    output logic [NUM_LANES-1:0] grant,
    output logic [3:0]           rand_out,
    output logic                 busy
);

    typedef enum logic [1:0] {
        StIdle,
        StSelect,
        StCapture
    } state_e;

    state_e               state_q, state_d;
    logic [2:0]           sel_q, sel_d;
    logic [2:0]           ptr_q, ptr_d;
    logic [2:0]           mode_q, mode_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [3:0]           rand_q, rand_d;
    logic [NUM_LANES-1:0] grant_q, grant_d;
`ifdef RNG_REJECT_ZERO_EN
    logic [1:0]           retry_q, retry_d;
`endif

    logic [7:0] req_ext;
    logic [7:0] elig;
    logic       found;
    logic [2:0] pick;
    logic [3:0] sel_inc;

    // Widen to 8 bits so any 3-bit lane index selects a real bit.
    assign req_ext = 8'(req);
    assign elig    = 8'(req & ~grant_q);
    assign sel_inc = {1'b0, sel_q} + 4'd1;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin : rr_pick
        logic [3:0] idx;
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            idx = {1'b0, ptr_q} + 4'(k);
            if (idx >= 4'(NUM_LANES)) begin
                idx = idx - 4'(NUM_LANES);
            end
            if (elig[idx[2:0]]) begin
                found = 1'b1;
                pick  = idx[2:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        rand_d  = rand_q;
        grant_d = '0;
`ifdef RNG_REJECT_ZERO_EN
        retry_d = retry_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    sel_d   = pick;
                    mode_d  = pick;
                    cnt_d   = 4'(SETTLE);
                    state_d = StSelect;
`ifdef RNG_REJECT_ZERO_EN
                    retry_d = 2'd0;
`endif
                end
            end
            StSelect: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                state_d = StIdle;
                if (req_ext[sel_q]) begin
`ifdef RNG_REJECT_ZERO_EN
                    if (rng_value == 4'h0 && retry_q != 2'd3) begin
                        retry_d = retry_q + 2'd1;
                        cnt_d   = 4'(SETTLE);
                        state_d = StSelect;
                    end else begin
                        rand_d  = (rng_value == 4'h0) ? 4'h1 : rng_value;
                        grant_d = NUM_LANES'(8'd1 << sel_q);
                        ptr_d   = (sel_inc >= 4'(NUM_LANES)) ? 3'd0 : sel_q + 3'd1;
                    end
`else
                    rand_d  = rng_value;
                    grant_d = NUM_LANES'(8'd1 << sel_q);
                    ptr_d   = (sel_inc >= 4'(NUM_LANES)) ? 3'd0 : sel_q + 3'd1;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            sel_q   <= '0;
            ptr_q   <= '0;
            mode_q  <= '0;
            cnt_q   <= '0;
            rand_q  <= '0;
            grant_q <= '0;
`ifdef RNG_REJECT_ZERO_EN
            retry_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            rand_q  <= rand_d;
            grant_q <= grant_d;
`ifdef RNG_REJECT_ZERO_EN
            retry_q <= retry_d;
`endif
        end
    end

    assign rng_mode = mode_q;
    assign grant    = grant_q;
    assign rand_out = rand_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_rng_spawn_scheduler.sv
// Self-checking bench for rng_spawn_scheduler: directed scenarios plus a randomized run
// checked against a transaction-timing model.
module tb_rng_spawn_scheduler;

    localparam int unsigned N  = 4;
    localparam int unsigned S  = 1;
    localparam int unsigned N8 = 8;
    localparam int unsigned S8 = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  req = '0;
    logic [3:0]    rng_value = '0;
    logic [2:0]    rng_mode;
    logic [N-1:0]  grant;
    logic [3:0]    rand_out;
    logic          busy;
    logic [N8-1:0] req8 = '0;
    logic [3:0]    rng_value8 = '0;
    logic [2:0]    rng_mode8;
    logic [N8-1:0] grant8;
    logic [3:0]    rand_out8;
    logic          busy8;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rng_spawn_scheduler #(.NUM_LANES(N), .SETTLE(S)) dut (
        .clk(clk), .rst(rst), .req(req), .rng_value(rng_value),
        .rng_mode(rng_mode), .grant(grant), .rand_out(rand_out), .busy(busy)
    );

    rng_spawn_scheduler #(.NUM_LANES(N8), .SETTLE(S8)) dut8 (
        .clk(clk), .rst(rst), .req(req8), .rng_value(rng_value8),
        .rng_mode(rng_mode8), .grant(grant8), .rand_out(rand_out8), .busy(busy8)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req  = '0;
        req8 = '0;
        repeat (n) step();
    endtask

    task automatic do_reset();
        req = '0; req8 = '0;
        rst = 1'b0;
        repeat (2) step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) step();
        tests++; if (grant !== 4'b0) begin fails++; $display("FAIL reset_grant: got %b want 0", grant); end
        tests++; if (rand_out !== 4'h0) begin fails++; $display("FAIL reset_rand: got %h want 0", rand_out); end
        tests++; if (rng_mode !== 3'd0) begin fails++; $display("FAIL reset_mode: got %0d want 0", rng_mode); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (grant8 !== 8'h0) begin fails++; $display("FAIL reset_grant8: got %h want 0", grant8); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_single();
        idle(2);
        req = 4'b0100; rng_value = 4'hA;
        step();
        tests++; if (rng_mode !== 3'd2) begin fails++; $display("FAIL single_mode: got %0d want 2", rng_mode); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy: got %b want 1", busy); end
        step();
        tests++; if (grant !== 4'b0) begin fails++; $display("FAIL single_early: got %b want 0", grant); end
        step();
        tests++; if (grant !== 4'b0100) begin fails++; $display("FAIL single_grant: got %b want 0100", grant); end
        tests++; if (rand_out !== 4'hA) begin fails++; $display("FAIL single_rand: got %h want a", rand_out); end
        req = '0; rng_value = 4'h3;
        step();
        tests++; if (grant !== 4'b0) begin fails++; $display("FAIL single_pulse: got %b want 0", grant); end
        tests++; if (rand_out !== 4'hA) begin fails++; $display("FAIL single_hold: got %h want a", rand_out); end
    endtask

    task automatic test_reset_mid();
        idle(2);
        req = 4'b1000; rng_value = 4'h7;
        step();
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy_pre: got %b want 1", busy); end
        #2 rst = 1'b0;
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy: got %b want 0", busy); end
        tests++; if (rng_mode !== 3'd0) begin fails++; $display("FAIL mid_mode: got %0d want 0", rng_mode); end
        tests++; if (rand_out !== 4'h0) begin fails++; $display("FAIL mid_rand: got %h want 0", rand_out); end
        step();
        tests++; if (grant !== 4'b0) begin fails++; $display("FAIL mid_grant: got %b want 0", grant); end
        rst = 1'b1;
        req = 4'b1010; rng_value = 4'h6;
        repeat (3) step();
        tests++; if (grant !== 4'b0010) begin fails++; $display("FAIL mid_lowest: got %b want 0010", grant); end
        tests++; if (rand_out !== 4'h6) begin fails++; $display("FAIL mid_value: got %h want 6", rand_out); end
        req = '0;
    endtask

    task automatic test_rotation();
        logic [N-1:0] dropped;
        logic [N-1:0] exp;
        do_reset();
        dropped = '0;
        req = 4'b1111;
        for (int c = 1; c <= 15; c++) begin
            rng_value = 4'($urandom_range(0, 15));
            step();
            exp = '0;
            if (c % 3 == 0) exp[((c / 3) - 1) % N] = 1'b1;
            tests++;
            if (grant !== exp) begin
                fails++; $display("FAIL rotation_c%0d: got %b want %b", c, grant, exp);
            end
            req = (req | dropped) & ~grant;
            dropped = grant;
        end
        req = '0;
    endtask

    task automatic test_abandon();
        idle(2);
        req = 4'b0001; rng_value = 4'h9;
        repeat (3) step();
        tests++; if (grant !== 4'b0001) begin fails++; $display("FAIL abandon_setup: got %b want 0001", grant); end
        req = '0;
        step();
        req = 4'b0010; rng_value = 4'h4;
        step();
        req = '0;
        step();
        tests++; if (grant !== 4'b0) begin fails++; $display("FAIL abandon_nogrant: got %b want 0", grant); end
        step();
        tests++; if (grant !== 4'b0) begin fails++; $display("FAIL abandon_nogrant2: got %b want 0", grant); end
        tests++; if (rand_out !== 4'h9) begin fails++; $display("FAIL abandon_rand: got %h want 9", rand_out); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abandon_idle: got %b want 0", busy); end
        req = 4'b0011; rng_value = 4'h2;
        repeat (3) step();
        tests++; if (grant !== 4'b0010) begin fails++; $display("FAIL abandon_ptr: got %b want 0010", grant); end
        req = '0;
    endtask

    task automatic test_wide();
        idle(2);
        req8 = 8'h80; rng_value8 = 4'hC;
        step();
        tests++; if (rng_mode8 !== 3'd7) begin fails++; $display("FAIL wide_mode: got %0d want 7", rng_mode8); end
        repeat (4) step();
        tests++; if (grant8 !== 8'h0) begin fails++; $display("FAIL wide_early: got %h want 0", grant8); end
        step();
        tests++; if (grant8 !== 8'h80) begin fails++; $display("FAIL wide_grant: got %h want 80", grant8); end
        tests++; if (rand_out8 !== 4'hC) begin fails++; $display("FAIL wide_rand: got %h want c", rand_out8); end
        req8 = 8'h00;
        step();
        req8 = 8'h41; rng_value8 = 4'h5;
        step();
        tests++; if (rng_mode8 !== 3'd0) begin fails++; $display("FAIL wide_wrap: got %0d want 0", rng_mode8); end
        repeat (5) step();
        tests++; if (grant8 !== 8'h01) begin fails++; $display("FAIL wide_wrap_grant: got %h want 01", grant8); end
        req8 = 8'h00;
    endtask

    task automatic test_zero();
        logic [N-1:0] exp;
        idle(2);
        req = 4'b0001; rng_value = 4'h0;
`ifdef RNG_REJECT_ZERO_EN
        for (int c = 1; c <= 7; c++) begin
            step();
            if (c == 5) rng_value = 4'h5;
            exp = (c == 7) ? 4'b0001 : 4'b0000;
            tests++;
            if (grant !== exp) begin fails++; $display("FAIL zero_retry_c%0d: got %b want %b", c, grant, exp); end
        end
        tests++; if (rand_out !== 4'h5) begin fails++; $display("FAIL zero_retry_rand: got %h want 5", rand_out); end
        idle(1);
        req = 4'b0001; rng_value = 4'h0;
        for (int c = 1; c <= 9; c++) begin
            step();
            exp = (c == 9) ? 4'b0001 : 4'b0000;
            tests++;
            if (grant !== exp) begin fails++; $display("FAIL zero_all_c%0d: got %b want %b", c, grant, exp); end
        end
        tests++; if (rand_out !== 4'h1) begin fails++; $display("FAIL zero_all_rand: got %h want 1", rand_out); end
`else
        for (int c = 1; c <= 3; c++) begin
            step();
            exp = (c == 3) ? 4'b0001 : 4'b0000;
            tests++;
            if (grant !== exp) begin fails++; $display("FAIL zero_plain_c%0d: got %b want %b", c, grant, exp); end
        end
        tests++; if (rand_out !== 4'h0) begin fails++; $display("FAIL zero_plain_rand: got %h want 0", rand_out); end
`endif
        req = '0;
    endtask

    // Model tracks each service as (lane, arbitration cycle, capture cycle, grant cycle).
    task automatic test_random();
        int           arb_at, capture_at, grant_at, lane, ptr, l;
        int           retries;
        logic         active, found, exp_busy;
        logic [3:0]   exp_rand, cap_val;
        logic [2:0]   exp_mode;
        logic [N-1:0] exp_grant, granted_prev, req_v, elig;
        do_reset();
        active = 1'b0; ptr = 0; lane = 0; retries = 0;
        arb_at = 0; capture_at = 0; grant_at = 0;
        exp_rand = '0; cap_val = '0; exp_mode = '0; granted_prev = '0;
        for (int c = 0; c < 600; c++) begin
            exp_busy  = active && (c > arb_at) && (c < grant_at);
            exp_grant = '0;
            if (active && c == grant_at) begin
                exp_grant[lane] = 1'b1;
                exp_rand = cap_val;
                ptr = (lane + 1) % N;
                active = 1'b0;
            end
            tests++; if (grant !== exp_grant) begin fails++; $display("FAIL rand_grant_c%0d: got %b want %b", c, grant, exp_grant); end
            tests++; if (rand_out !== exp_rand) begin fails++; $display("FAIL rand_value_c%0d: got %h want %h", c, rand_out, exp_rand); end
            tests++; if (busy !== exp_busy) begin fails++; $display("FAIL rand_busy_c%0d: got %b want %b", c, busy, exp_busy); end
            tests++; if (rng_mode !== exp_mode) begin fails++; $display("FAIL rand_mode_c%0d: got %0d want %0d", c, rng_mode, exp_mode); end

            req_v = req & ~granted_prev;
            for (int i = 0; i < N; i++) begin
                if (!req_v[i] && !granted_prev[i] && $urandom_range(0, 2) == 0) req_v[i] = 1'b1;
            end
            req = req_v;
            rng_value = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            granted_prev = exp_grant;

            if (active && c == capture_at) begin
`ifdef RNG_REJECT_ZERO_EN
                if (rng_value == 4'h0 && retries < 3) begin
                    retries++;
                    capture_at += S + 1;
                    grant_at   += S + 1;
                end else begin
                    cap_val = (rng_value == 4'h0) ? 4'h1 : rng_value;
                end
`else
                cap_val = rng_value;
`endif
            end
            elig = req & ~exp_grant;
            if (!exp_busy && elig != '0) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    l = (ptr + k) % N;
                    if (!found && elig[l]) begin
                        lane = l;
                        found = 1'b1;
                    end
                end
                active = 1'b1; arb_at = c; capture_at = c + S + 1; grant_at = c + S + 2;
                exp_mode = 3'(lane); retries = 0;
            end
            step();
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_reset_mid();
        test_rotation();
        test_abandon();
        test_wide();
        test_zero();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
